// File: rtl/kgp_disp_pkg.sv
// kgp_disp_pkg
// Shared constants for the KGP_RISC result display: default parameter
// values, the active-low seven-segment code table (bit order {g,f,e,d,c,b,a})
// and the blank code.
package kgp_disp_pkg;

  localparam int REFRESH_DIV_DEF = 50000;
  localparam int STABLE_CYC_DEF  = 4;
  localparam int LZ_BLANK_DEF    = 1;

  // Refresh counter width covers REFRESH_DIV up to 2^20.
  localparam int REFRESH_CNT_W   = 20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed table, index 15 first so that SEG_TABLE[n] is the code for hex n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
// Combinational hex digit to active-low seven-segment decoder.
// Ports:
//   nibble  in  4  hex digit value
//   seg_n   out 7  active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import kgp_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/rout_seg_display.sv
// rout_seg_display
// Shows the 16-bit KGP_RISC result bus on a 4-digit multiplexed
// seven-segment display. The bus is debounced by a stability filter: a value
// must be sampled on STABLE_CYC consecutive edges before it is committed to
// the displayed value. Digits are scanned with a clock-enable style refresh
// counter; all display outputs are registered.
// Ports:
//   clk      in  1   system clock, rising edge
//   reset    in  1   synchronous active-high reset
//   rout     in  16  processor result bus
//   seg      out 7   active-low segments {g,f,e,d,c,b,a}
//   an       out 4   active-low digit enables, an[0] = rightmost digit
//   dp       out 1   active-low decimal point, low while an update is pending
//                    and the leftmost digit is lit
//   upd_cnt  out 8   number of committed display updates (wraps)
module rout_seg_display
  import kgp_disp_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int STABLE_CYC  = STABLE_CYC_DEF,
  parameter int LZ_BLANK    = LZ_BLANK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rout,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [7:0]  upd_cnt
);

  localparam logic [REFRESH_CNT_W-1:0] REFRESH_LAST = REFRESH_CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]               STABLE_TGT   = 8'(STABLE_CYC);

  logic [15:0]              cand_q, cand_d;
  logic [7:0]               stab_q, stab_d;
  logic [15:0]              shown_q, shown_d;
  logic [7:0]               upd_cnt_q, upd_cnt_d;
  logic [REFRESH_CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]               digit_q, digit_d;
  logic [6:0]               seg_q, seg_d;
  logic [3:0]               an_q, an_d;
  logic                     dp_q, dp_d;

  logic [3:0]               nibble_s;
  logic                     blank_s;
  logic [6:0]               hex_seg_s;

  // Stability filter and commit of the candidate into the shown value.
  always_comb begin
    cand_d    = cand_q;
    stab_d    = stab_q;
    shown_d   = shown_q;
    upd_cnt_d = upd_cnt_q;
    if (rout != cand_q) begin
      // New value restarts the run length at one sample.
      cand_d = rout;
      stab_d = 8'd1;
    end else begin
      if (stab_q < STABLE_TGT) begin
        stab_d = stab_q + 8'd1;
      end else begin
        stab_d = stab_q;
      end
      // Commit once the run is long enough; a candidate equal to the shown
      // value is not an update and is not counted.
      if ((stab_d >= STABLE_TGT) && (cand_q != shown_q)) begin
        shown_d   = cand_q;
        upd_cnt_d = upd_cnt_q + 8'd1;
      end else begin
        shown_d   = shown_q;
        upd_cnt_d = upd_cnt_q;
      end
    end
  end

  // Refresh counter acts as the scan enable; digit index advances on wrap.
  always_comb begin
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      digit_d       = digit_q + 2'd1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + REFRESH_CNT_W'(1);
      digit_d       = digit_q;
    end
  end

  // Nibble select and leading-zero blanking for the active digit.
  always_comb begin
    nibble_s = shown_q[3:0];
    blank_s  = 1'b0;
    case (digit_q)
      2'd0: begin
        nibble_s = shown_q[3:0];
        blank_s  = 1'b0;
      end
      2'd1: begin
        nibble_s = shown_q[7:4];
        blank_s  = (LZ_BLANK != 0) && (shown_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s = shown_q[11:8];
        blank_s  = (LZ_BLANK != 0) && (shown_q[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s = shown_q[15:12];
        blank_s  = (LZ_BLANK != 0) && (shown_q[15:12] == 4'h0);
      end
      default: begin
        nibble_s = shown_q[3:0];
        blank_s  = 1'b0;
      end
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_s),
    .seg_n  (hex_seg_s)
  );

  // Next output register values from the current digit and shown value.
  always_comb begin
    if (blank_s) begin
      seg_d = SEG_BLANK;
      an_d  = 4'hF;
    end else begin
      seg_d = hex_seg_s;
      an_d  = ~(4'b0001 << digit_q);
    end
    dp_d = ~((digit_q == 2'd3) && (cand_q != shown_q));
  end

  // State and output registers; reset wins over any commit or wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q        <= 16'h0000;
      stab_q        <= 8'd0;
      shown_q       <= 16'h0000;
      upd_cnt_q     <= 8'd0;
      refresh_cnt_q <= '0;
      digit_q       <= 2'd0;
      seg_q         <= SEG_TABLE[4'h0];
      an_q          <= 4'b1110;
      dp_q          <= 1'b1;
    end else begin
      cand_q        <= cand_d;
      stab_q        <= stab_d;
      shown_q       <= shown_d;
      upd_cnt_q     <= upd_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_q       <= digit_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = dp_q;
  assign upd_cnt = upd_cnt_q;

endmodule
